// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed N-digit seven-segment display controller.
//
// A small register file holds a hex value and a decimal-point bit per digit and
// is loaded through a simple write port. An internal prescaler defines how long
// each digit stays selected. After every digit switch all anodes are held off
// for GUARD cycles so the previous digit's pattern never ghosts onto the next
// anode. Per-digit enables and a global blank gate the anodes only; cathodes
// keep following the scanned digit so scanning is never disturbed.
//
// All outputs are registered (one cycle behind the internal scan state) and
// drive the board's active-low cathodes and anodes directly.
//
// Parameters
//   NUM_DIGITS   number of digits / anodes (>= 2)
//   REFRESH_DIV  clk cycles each digit is selected (>= GUARD + 2)
//   GUARD        anti-ghost cycles with all anodes off after a switch (>= 0)
//   IDX_W        derived digit index width
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   register file write strobe
//   wr_addr    in   digit index to write; indices >= NUM_DIGITS are ignored
//   wr_data    in   hex value 0x0..0xF
//   wr_dp      in   decimal point for that digit, 1 = lit
//   digit_en   in   per-digit enable, 0 = digit blanked
//   blank      in   global blank, 1 = all anodes off
//   seg        out  cathodes {G,F,E,D,C,B,A}, active-low
//   dp         out  decimal-point cathode, active-low
//   an         out  anodes, active-low, at most one low at a time
//   scan_idx   out  digit currently being scanned
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic [IDX_W-1:0]      scan_idx
);

    localparam int PS_W = $clog2(REFRESH_DIV);
    localparam int GD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GD_W-1:0]  GUARD_LD = GD_W'(GUARD);

    typedef struct packed {
        logic       dp;
        logic [3:0] val;
    } digit_t;

    typedef enum logic {
        GUARD_OFF = 1'b0,
        DRIVE     = 1'b1
    } state_t;

    // State every scan slot starts in; with no guard interval the slot drives
    // immediately and GUARD_OFF is never visited.
    localparam state_t SLOT_START = (GUARD > 0) ? GUARD_OFF : DRIVE;

    // Active-low gfedcba pattern for a hex value.
    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] f;
        unique case (v)
            4'h0: f = 7'h40;
            4'h1: f = 7'h79;
            4'h2: f = 7'h24;
            4'h3: f = 7'h30;
            4'h4: f = 7'h19;
            4'h5: f = 7'h12;
            4'h6: f = 7'h02;
            4'h7: f = 7'h78;
            4'h8: f = 7'h00;
            4'h9: f = 7'h10;
            4'hA: f = 7'h08;
            4'hB: f = 7'h03;
            4'hC: f = 7'h46;
            4'hD: f = 7'h21;
            4'hE: f = 7'h06;
            4'hF: f = 7'h0E;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    digit_t          regfile [NUM_DIGITS];
    logic [PS_W-1:0] presc_q;
    logic [GD_W-1:0] guard_q;
    state_t          state_q, state_d;
    logic            wrap;
    logic            wr_ok;

    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;

    assign wrap  = (presc_q == PS_LAST);
    assign wr_ok = wr_en && ({1'b0, wr_addr} < (IDX_W + 1)'(NUM_DIGITS));

    // -------------------------------------------------------------------------
    // Digit register file. The write target depends only on wr_addr, so a
    // write landing on the same edge as a scan advance is unaffected by it.
    // -------------------------------------------------------------------------
    // NOTE: the register file is only NUM_DIGITS x 5 flops, so it is reset like
    // any other register; a blank display after reset needs known contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regfile[i] <= '0;
            end
        end else if (wr_ok) begin
            regfile[wr_addr] <= '{dp: wr_dp, val: wr_data};
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler, scan index and guard counter. The prescaler wrap edge both
    // advances the digit and re-arms the guard interval for the new slot.
    // -------------------------------------------------------------------------
    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            scan_idx <= '0;
            guard_q  <= GUARD_LD;
        end else begin
            if (wrap) begin
                presc_q  <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
                guard_q  <= GUARD_LD;
            end else begin
                presc_q <= presc_q + 1'b1;
                if (guard_q != '0) begin
                    guard_q <= guard_q - 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slot FSM: state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_START;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Slot FSM: next state and next output values.
    // DRIVE is entered on the edge where the guard counter reaches zero, so the
    // state always equals (guard_q == 0).
    // -------------------------------------------------------------------------
    // NOTE: every variable written here receives a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        an_d    = '1;
        seg_d   = font(regfile[scan_idx].val);
        dp_d    = ~regfile[scan_idx].dp;

        unique case (state_q)
            GUARD_OFF: begin
                if (wrap) begin
                    state_d = SLOT_START;
                end else if (guard_q <= GD_W'(1)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (wrap) begin
                    state_d = SLOT_START;
                end
            end
            default: state_d = SLOT_START;
        endcase

        // Only the scanned digit can ever be pulled low, which keeps the
        // at-most-one-anode guarantee structural.
        if (state_q == DRIVE && !blank && digit_en[scan_idx]) begin
            an_d[scan_idx] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs: glitch-free pins, one cycle behind the scan state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Self-checking bench for seg7_scan_ctrl. Two instances share clock and reset:
//   dut : 4 digits, 8-cycle slots, 2-cycle guard
//   u6  : 6 digits, 8-cycle slots, no guard (exercises out-of-range addresses)
// The reference model describes the display by edge count since reset release:
// before edge t the slot position is t mod R and the scanned digit is
// (t div R) mod N; a digit is lit once the slot position reaches the guard.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int G  = 2;
    localparam int N6 = 6;
    localparam int G6 = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut stimulus / response
    logic         wr_en = 1'b0;
    logic [1:0]   wr_addr = '0;
    logic [3:0]   wr_data = '0;
    logic         wr_dp = 1'b0;
    logic [N-1:0] digit_en = '1;
    logic         blank = 1'b0;
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic [1:0]   scan_idx;

    // u6 stimulus / response
    logic          w6_en = 1'b0;
    logic [2:0]    w6_addr = '0;
    logic [3:0]    w6_data = '0;
    logic          w6_dp = 1'b0;
    logic [N6-1:0] en6 = '1;
    logic          blank6 = 1'b0;
    logic [6:0]    seg6;
    logic          dp6;
    logic [N6-1:0] an6;
    logic [2:0]    idx6;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
        .digit_en(digit_en), .blank(blank),
        .seg(seg), .dp(dp), .an(an), .scan_idx(scan_idx)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(N6), .REFRESH_DIV(R), .GUARD(G6)) u6 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(w6_en), .wr_addr(w6_addr), .wr_data(w6_data), .wr_dp(w6_dp),
        .digit_en(en6), .blank(blank6),
        .seg(seg6), .dp(dp6), .an(an6), .scan_idx(idx6)
    );

    // Font reference: value 0..F -> active-low gfedcba.
    logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    // Model state and the expected outputs after the most recent edge.
    int            t;
    logic [4:0]    m4 [N];
    logic [4:0]    m6 [N6];
    logic [N-1:0]  e_an;
    logic [6:0]    e_seg;
    logic          e_dp;
    logic [1:0]    e_idx;
    logic [N6-1:0] e6_an;
    logic [6:0]    e6_seg;
    logic          e6_dp;
    logic [2:0]    e6_idx;

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) m4[i] = '0;
        for (int i = 0; i < N6; i++) m6[i] = '0;
        e_idx  = '0;
        e6_idx = '0;
    endtask

    // Advance one rising edge: predict outputs from the pre-edge state, apply
    // this edge's writes to the model, then sample point = edge + 1.
    task automatic tick();
        int p;
        int d;
        logic [4:0] r;
        p = t % R;
        d = (t / R) % N;
        e_an = '1;
        if (p >= G && !blank && digit_en[d]) e_an[d] = 1'b0;
        r = m4[d];
        e_seg = font_tbl[r[3:0]];
        e_dp  = ~r[4];
        d = (t / R) % N6;
        e6_an = '1;
        if (p >= G6 && !blank6 && en6[d]) e6_an[d] = 1'b0;
        r = m6[d];
        e6_seg = font_tbl[r[3:0]];
        e6_dp  = ~r[4];
        if (wr_en) m4[wr_addr] = {wr_dp, wr_data};
        if (w6_en && w6_addr < 3'(N6)) m6[w6_addr] = {w6_dp, w6_data};
        t++;
        e_idx  = 2'((t / R) % N);
        e6_idx = 3'((t / R) % N6);
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        wr_en = 0; w6_en = 0; digit_en = '1; blank = 0; en6 = '1; blank6 = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (an !== 4'hF)   begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
        checks++; if (dp !== 1'b1)   begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", scan_idx); end
        checks++; if (an6 !== '1)    begin errors++; $display("FAIL reset_an6 got %b exp all 1", an6); end
        model_reset();
        rst_n = 1;
        for (int k = 1; k <= G + 1; k++) begin
            tick();
            if (k <= G) begin
                checks++; if (an !== 4'hF) begin errors++; $display("FAIL release_guard k=%0d got %b exp 1111", k, an); end
            end else begin
                checks++; if (an !== 4'b1110) begin errors++; $display("FAIL release_first k=%0d got %b exp 1110", k, an); end
            end
            checks++; if (seg !== 7'h40) begin errors++; $display("FAIL release_seg k=%0d got %h exp 40", k, seg); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_scan();
        logic [6:0] cseg [N] = '{7'h79, 7'h24, 7'h08, 7'h0E};
        logic [3:0] vals [N] = '{4'h1, 4'h2, 4'hA, 4'hF};
        int low_run, gap_run, prev_d, d;
        bit low_ok, seen_low;
        for (int i = 0; i < N; i++) begin
            wr_en = 1; wr_addr = 2'(i); wr_data = vals[i]; wr_dp = (i == 2);
            tick();
        end
        wr_en = 0;
        tick();
        low_run = 0; gap_run = 0; prev_d = -1; low_ok = 0; seen_low = 0;
        for (int c = 0; c < 2 * N * R + 4; c++) begin
            tick();
            checks++; if (an !== e_an) begin errors++; $display("FAIL scan_an t=%0d got %b exp %b", t, an, e_an); end
            checks++; if (scan_idx !== e_idx) begin errors++; $display("FAIL scan_idx t=%0d got %0d exp %0d", t, scan_idx, e_idx); end
            if (an == 4'hF) begin
                if (low_run > 0 && low_ok) begin
                    checks++; if (low_run != R - G) begin errors++; $display("FAIL scan_low_len got %0d exp %0d", low_run, R - G); end
                end
                if (low_run > 0) seen_low = 1;
                low_run = 0;
                gap_run++;
            end else begin
                d = -1;
                for (int i = 0; i < N; i++) if (an[i] == 1'b0) d = i;
                if (low_run == 0) begin
                    low_ok = (gap_run > 0);
                    if (gap_run > 0 && seen_low) begin
                        checks++; if (gap_run != G) begin errors++; $display("FAIL scan_gap_len got %0d exp %0d", gap_run, G); end
                        checks++; if (d != (prev_d + 1) % N) begin errors++; $display("FAIL scan_order got %0d exp %0d", d, (prev_d + 1) % N); end
                    end
                end
                checks++; if (seg !== cseg[d]) begin errors++; $display("FAIL scan_seg digit=%0d got %h exp %h", d, seg, cseg[d]); end
                checks++; if (dp !== (d != 2)) begin errors++; $display("FAIL scan_dp digit=%0d got %b exp %b", d, dp, d != 2); end
                gap_run = 0;
                low_run++;
                prev_d = d;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_blanking();
        digit_en = 4'b1011;
        for (int c = 0; c < 2 * N * R; c++) begin
            tick();
            checks++; if (an[2] !== 1'b1) begin errors++; $display("FAIL blank_digit2 t=%0d got an=%b exp an[2]=1", t, an); end
            checks++; if (an !== e_an) begin errors++; $display("FAIL blank_en_an t=%0d got %b exp %b", t, an, e_an); end
            checks++; if (scan_idx !== e_idx) begin errors++; $display("FAIL blank_en_idx t=%0d got %0d exp %0d", t, scan_idx, e_idx); end
        end
        digit_en = '1;
        blank = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (an !== 4'hF) begin errors++; $display("FAIL blank_global_an t=%0d got %b exp 1111", t, an); end
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL blank_global_seg t=%0d got %h exp %h", t, seg, e_seg); end
        end
        blank = 0;
        tick();
        checks++; if (an !== e_an) begin errors++; $display("FAIL unblank_an t=%0d got %b exp %b", t, an, e_an); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_live_write();
        int d, nd, budget;
        budget = 0;
        while (t % R != G + 1 && budget < 4 * R) begin tick(); budget++; end
        d = (t / R) % N;
        wr_en = 1; wr_addr = 2'(d); wr_data = 4'h8; wr_dp = 0;
        tick();
        wr_en = 0;
        checks++; if (an[d] !== 1'b0) begin errors++; $display("FAIL live_an_write_edge digit=%0d got %b", d, an); end
        checks++; if (seg !== e_seg) begin errors++; $display("FAIL live_seg_old got %h exp %h", seg, e_seg); end
        tick();
        checks++; if (an[d] !== 1'b0) begin errors++; $display("FAIL live_an_after digit=%0d got %b", d, an); end
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL live_seg_new got %h exp 00", seg); end
        // write on the wrap edge, aimed at the digit being switched to
        budget = 0;
        while (t % R != R - 1 && budget < 4 * R) begin tick(); budget++; end
        nd = ((t / R) + 1) % N;
        wr_en = 1; wr_addr = 2'(nd); wr_data = 4'h8; wr_dp = 1;
        tick();
        wr_en = 0;
        checks++; if (scan_idx !== 2'(nd)) begin errors++; $display("FAIL wrap_idx got %0d exp %0d", scan_idx, nd); end
        tick();
        checks++; if (seg !== 7'h00) begin errors++; $display("FAIL wrap_write_seg got %h exp 00", seg); end
        checks++; if (dp !== 1'b0) begin errors++; $display("FAIL wrap_write_dp got %b exp 0", dp); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL wrap_guard_an got %b exp 1111", an); end
        for (int c = 0; c < N * R; c++) begin
            tick();
            checks++; if (seg !== e_seg || dp !== e_dp) begin errors++; $display("FAIL live_follow t=%0d got %h/%b exp %h/%b", t, seg, dp, e_seg, e_dp); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_illegal_addr();
        int d;
        for (int i = 0; i < N6; i++) begin
            w6_en = 1; w6_addr = 3'(i); w6_data = 4'(i + 3); w6_dp = i[0];
            tick();
        end
        w6_en = 1; w6_addr = 3'd7; w6_data = 4'hE; w6_dp = 1;
        tick();
        w6_addr = 3'd6; w6_data = 4'hD;
        tick();
        w6_en = 0;
        for (int c = 0; c < N6 * R; c++) begin
            tick();
            checks++; if (an6 !== e6_an) begin errors++; $display("FAIL ill_an6 t=%0d got %b exp %b", t, an6, e6_an); end
            checks++; if (idx6 !== e6_idx) begin errors++; $display("FAIL ill_idx6 t=%0d got %0d exp %0d", t, idx6, e6_idx); end
            d = -1;
            for (int i = 0; i < N6; i++) if (an6[i] == 1'b0) d = i;
            if (d >= 0) begin
                checks++; if (seg6 !== font_tbl[d + 3]) begin errors++; $display("FAIL ill_seg6 digit=%0d got %h exp %h", d, seg6, font_tbl[d + 3]); end
                checks++; if (dp6 !== ~d[0]) begin errors++; $display("FAIL ill_dp6 digit=%0d got %b exp %b", d, dp6, ~d[0]); end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_font();
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < N; i++) begin
                wr_en = 1; wr_addr = 2'(i); wr_data = 4'(v); wr_dp = 0;
                tick();
            end
            wr_en = 0;
            tick();
            checks++; if (seg !== font_tbl[v]) begin errors++; $display("FAIL font v=%h got %h exp %h", v, seg, font_tbl[v]); end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom_range(2) == 0);
            wr_addr = 2'($urandom_range(N - 1));
            wr_data = 4'($urandom);
            wr_dp   = 1'($urandom);
            w6_en   = ($urandom_range(2) == 0);
            w6_addr = 3'($urandom_range(7));
            w6_data = 4'($urandom);
            w6_dp   = 1'($urandom);
            if ($urandom_range(15) == 0) digit_en = 4'($urandom);
            if ($urandom_range(15) == 0) en6 = 6'($urandom);
            if ($urandom_range(31) == 0) blank = ~blank;
            if ($urandom_range(31) == 0) blank6 = ~blank6;
            tick();
            checks++; if (an !== e_an || seg !== e_seg || dp !== e_dp || scan_idx !== e_idx) begin
                errors++; $display("FAIL rand_dut t=%0d got an=%b seg=%h dp=%b idx=%0d exp an=%b seg=%h dp=%b idx=%0d",
                                   t, an, seg, dp, scan_idx, e_an, e_seg, e_dp, e_idx);
            end
            checks++; if (an6 !== e6_an || seg6 !== e6_seg || dp6 !== e6_dp || idx6 !== e6_idx) begin
                errors++; $display("FAIL rand_u6 t=%0d got an=%b seg=%h dp=%b idx=%0d exp an=%b seg=%h dp=%b idx=%0d",
                                   t, an6, seg6, dp6, idx6, e6_an, e6_seg, e6_dp, e6_idx);
            end
            checks++; if ($countones(~an) > 1 || $countones(~an6) > 1) begin
                errors++; $display("FAIL rand_onehot t=%0d got an=%b an6=%b exp at most one low", t, an, an6);
            end
        end
        wr_en = 0; w6_en = 0; digit_en = '1; en6 = '1; blank = 0; blank6 = 0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_async_reset();
        int budget;
        budget = 0;
        while (t % R != G + 2 && budget < 4 * R) begin tick(); budget++; end
        tick();
        checks++; if (an === 4'hF) begin errors++; $display("FAIL areset_pre got %b exp one digit low", an); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (an !== 4'hF)   begin errors++; $display("FAIL areset_an got %b exp 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL areset_seg got %h exp 7f", seg); end
        checks++; if (dp !== 1'b1)   begin errors++; $display("FAIL areset_dp got %b exp 1", dp); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL areset_idx got %0d exp 0", scan_idx); end
        checks++; if (an6 !== '1 || seg6 !== 7'h7F) begin errors++; $display("FAIL areset_u6 got an=%b seg=%h exp all 1 / 7f", an6, seg6); end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
        for (int c = 0; c < 2 * N * R; c++) begin
            tick();
            checks++; if (an !== e_an || scan_idx !== e_idx || seg !== e_seg) begin
                errors++; $display("FAIL restart t=%0d got an=%b idx=%0d seg=%h exp an=%b idx=%0d seg=%h",
                                   t, an, scan_idx, seg, e_an, e_idx, e_seg);
            end
            checks++; if ($countones(~an) > 1) begin errors++; $display("FAIL restart_onehot t=%0d got %b exp at most one low", t, an); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_live_write();
        test_illegal_addr();
        test_font();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
